trimux_batcher: RTL and testbench
=================================

// Module: trimux_batcher
// PURPOSE
//  Packs a stream of variable-length elements into batches, one batch per VLEN-bit vector.
//  Lengths are counted in blocks of BLEN = VLEN/BS bits; one element arrives per handshake.
//  For each batch it builds the per-lane descriptor the trimux datapath consumes:
//  inum, ilen[], ipos[] and psum[]. It holds the descriptor until downstream accepts it.
//  Sits between the element-length front end and trimux.
// PARAMETERS
//  VLEN  256  vector width in bits
//  BSW   5    log2 of lanes/blocks per vector; BS = 1<<BSW, BLEN = VLEN/BS
//  WW    8-BSW+1  element-length field width in blocks; 2^WW-1 <= BS required
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  rst        in   1               synchronous, active-high reset
//  in_valid   in   1               element offered
//  in_ready   out  1               element accepted when in_valid && in_ready
//  in_len     in   WW              element length in blocks, legal 1..BS
//  in_last    in   1               element closes its batch (flush)
//  out_valid  out  1               batch descriptor valid
//  out_ready  in   1               descriptor consumed when out_valid && out_ready
//  out_inum   out  BSW+1           element count in batch, 1..BS
//  out_ilen   out  WW x BS         per-element length; lanes >= inum are 0
//  out_ipos   out  BSW x BS        exclusive prefix sum (start block); lanes >= inum are 0
//  out_psum   out  (BSW+1) x BS    inclusive prefix sum (end block); lanes >= inum are 0
//  err        out  1               sticky illegal-length flag
// BEHAVIOUR
//  Reset: state FILL; cnt=0, used=0, carry empty; all arrays 0.
//   Reset outputs: out_valid=0, in_ready=1, err=0, out_inum=0.
//   Reset mid-batch or mid-hold discards everything; nothing is emitted.
//  Registered state: cnt (BSW+1 bits), used (BSW+1 bits), carry register (len, last, valid), FSM {FILL, HOLD}.
//  in_ready = (state==FILL) && !carry_valid. Purely state-derived; never depends on in_len.
//  out_valid = (state==HOLD). All out_* are driven directly from registers.
//  FILL, element accepted with 1 <= len <= BS:
//   - Fits (used+len <= BS): write lane cnt with ilen=len, ipos=used, psum=used+len.
//     Then cnt++ and used+=len.
//     Go to HOLD if, after the update, cnt==BS or used==BS or in_last.
//   - Does not fit (cnt>0): latch {len, in_last} into carry and go to HOLD; the current batch is unchanged.
//  Illegal length (len==0 or len>BS): the element is consumed and dropped, err is set, state is unchanged.
//  Latency: out_valid rises the cycle after the accept that closes the batch.
//  HOLD: descriptor is stable; in_ready=0.
//   On out_ready: clear arrays, cnt and used.
//   If carry_valid: seed lane 0 from carry (ilen=len, ipos=0, psum=len), set cnt=1, used=len, clear carry.
//    Stay in HOLD if carry.last or len==BS; otherwise go to FILL.
//   If no carry: go to FILL.
//  out_ready while out_valid=0 is ignored.
//  An element can never straddle two batches. An empty batch is never emitted.
//  All arithmetic is unsigned and BSW+1 bits wide, with no wrap: used <= BS is guaranteed by the fit check.
// TESTING  (VLEN=256, BSW=5, WW=4, out_ready=1 unless stated)
//  1 Lens 4,6,3,2,2,3,5, last on 5 -> inum=7.
//    psum={4,10,13,15,17,20,25}, ipos={0,4,10,13,15,17,20}, lanes 7..31 = 0.
//  2 Lens 8,8,8,7 then 3 -> batch inum=4, psum[3]=31, emitted with in_ready=0.
//    Next batch then starts with lane0 len=3, ipos=0, psum=3.
//  3 Lens 8,8,8,8, no last -> out_valid the cycle after the 4th accept; inum=4, psum[3]=32.
//  4 32 lens of 1 -> inum=32, psum[31]=32, closes on the count cap.
//  5 out_ready=0 for 5 cycles in HOLD -> descriptor bit-stable; in_ready=0.
//    Single transfer when out_ready rises.
//  6 in_len=0 -> err=1 and sticky, element dropped.
//    rst after 3 accepts -> next batch starts ipos=0; err=0, out_valid=0 from the cycle after rst.

Source files
------------

// File: rtl/trimux_batcher_if.sv
// trimux_batcher_if: element-in / descriptor-out bundle for the trimux batcher
interface trimux_batcher_if #(
    parameter int BSW = 5,
    parameter int WW  = 8 - BSW + 1
);
    localparam int BS = 1 << BSW;
    logic                   in_valid;
    logic                   in_ready;
    logic [WW-1:0]          in_len;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [BSW:0]           out_inum;
    logic [BS-1:0][WW-1:0]  out_ilen;
    logic [BS-1:0][BSW-1:0] out_ipos;
    logic [BS-1:0][BSW:0]   out_psum;
    logic                   err;
    modport master (
        output in_valid, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_inum, out_ilen, out_ipos, out_psum, err
    );
    modport slave (
        input  in_valid, in_len, in_last, out_ready,
        output in_ready, out_valid, out_inum, out_ilen, out_ipos, out_psum, err
    );
endinterface

// File: rtl/trimux_batcher.sv
// trimux_batcher: packs variable-length elements into per-vector batch descriptors
module trimux_batcher #(
    parameter int VLEN = 256,
    parameter int BSW  = 5,
    parameter int WW   = 8 - BSW + 1
) (
    input logic             clk,
    input logic             rst,
    trimux_batcher_if.slave b
);
    localparam int BS = 1 << BSW;
    localparam logic [BSW:0] BSV = (BSW+1)'(BS);
    localparam logic [BSW:0] ONE = (BSW+1)'(1);
    if (((1 << WW) - 1) > BS || (VLEN % BS) != 0) begin : g_cfg
        $error("trimux_batcher: illegal parameter combination");
    end
    typedef enum logic {FILL, HOLD} state_t;
    state_t                 state, state_n;
    logic [BSW:0]           cnt, used, len_x, sum, clen_x;
    logic [WW-1:0]          c_len;
    logic                   c_last, c_valid, err_r;
    logic [BS-1:0][WW-1:0]  ilen;
    logic [BS-1:0][BSW-1:0] ipos;
    logic [BS-1:0][BSW:0]   psum;
    logic                   rdy, acc, bad, fits, close;
    assign rdy         = (state == FILL) && !c_valid;
    assign b.in_ready  = rdy;
    assign b.out_valid = (state == HOLD);
    assign b.out_inum  = cnt;
    assign b.out_ilen  = ilen;
    assign b.out_ipos  = ipos;
    assign b.out_psum  = psum;
    assign b.err       = err_r;
    // fit/close decode of the offered element and next-state selection
    always_comb begin
        len_x   = (BSW+1)'(b.in_len);
        clen_x  = (BSW+1)'(c_len);
        acc     = b.in_valid && rdy;
        bad     = (len_x == '0) || (len_x > BSV);
        sum     = used + len_x;
        fits    = sum <= BSV;
        close   = (cnt + ONE == BSV) || (sum == BSV) || b.in_last;
        state_n = state;
        if (state == FILL) begin
            if (acc && !bad) state_n = (!fits || close) ? HOLD : FILL;
        end else if (b.out_ready) begin
            state_n = (c_valid && (c_last || clen_x == BSV)) ? HOLD : FILL;
        end
    end
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? FILL : state_n;
    end
    // lane arrays, counters, carry slot and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            used    <= '0;
            c_len   <= '0;
            c_last  <= 1'b0;
            c_valid <= 1'b0;
            err_r   <= 1'b0;
            ilen    <= '0;
            ipos    <= '0;
            psum    <= '0;
        end else begin
            if (acc && bad) begin
                err_r <= 1'b1;
            end else if (acc && fits) begin
                ilen[cnt[BSW-1:0]] <= b.in_len;
                ipos[cnt[BSW-1:0]] <= used[BSW-1:0];
                psum[cnt[BSW-1:0]] <= sum;
                cnt                <= cnt + ONE;
                used               <= sum;
            end else if (acc) begin
                c_len   <= b.in_len;
                c_last  <= b.in_last;
                c_valid <= 1'b1;
            end
            if (state == HOLD && b.out_ready) begin
                ilen    <= '0;
                ipos    <= '0;
                psum    <= '0;
                cnt     <= c_valid ? ONE : '0;
                used    <= c_valid ? clen_x : '0;
                c_valid <= 1'b0;
                if (c_valid) begin
                    ilen[0] <= c_len;
                    psum[0] <= clen_x;
                end
            end
        end
    end
endmodule

// File: tb/tb_trimux_batcher.sv
// tb_trimux_batcher: scoreboard bench for trimux_batcher with directed vectors
module tb_trimux_batcher;
    localparam int BSW = 5;
    localparam int WW  = 4;
    localparam int BS  = 32;
    typedef struct {
        logic [BSW:0]           inum;
        logic [BS-1:0][WW-1:0]  ilen;
        logic [BS-1:0][BSW-1:0] ipos;
        logic [BS-1:0][BSW:0]   psum;
    } desc_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    trimux_batcher_if #(.BSW(BSW), .WW(WW)) bus();
    trimux_batcher #(.VLEN(256), .BSW(BSW), .WW(WW)) dut (.clk(clk), .rst(rst), .b(bus));
    desc_t q[$];
    desc_t cur;
    desc_t mon_e;
    int    cur_used = 0;
    int    tests = 0;
    int    fails = 0;
    logic [BSW:0]           s_inum;
    logic [BS-1:0][WW-1:0]  s_ilen;
    logic [BS-1:0][BSW-1:0] s_ipos;
    logic [BS-1:0][BSW:0]   s_psum;
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic clr();
        cur.inum = '0;
        cur.ilen = '0;
        cur.ipos = '0;
        cur.psum = '0;
        cur_used = 0;
    endtask
    task automatic add(input int len);
        cur.ilen[cur.inum] = WW'(len);
        cur.ipos[cur.inum] = BSW'(cur_used);
        cur_used += len;
        cur.psum[cur.inum] = (BSW+1)'(cur_used);
        cur.inum++;
    endtask
    task automatic push();
        q.push_back(cur);
        clr();
    endtask
    task automatic send(input int len, input logic last);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_len   = WW'(len);
        bus.in_last  = last;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed %0d, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_queue_empty", 256'(q.size()), 256'(0));
    endtask
    // monitor: every accepted descriptor is compared with the oldest expected batch
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_batch: got inum %0d, required no batch", bus.out_inum);
            end else begin
                mon_e = q.pop_front();
                chk("out_inum", 256'(bus.out_inum), 256'(mon_e.inum));
                chk("out_ilen", 256'(bus.out_ilen), 256'(mon_e.ilen));
                chk("out_ipos", 256'(bus.out_ipos), 256'(mon_e.ipos));
                chk("out_psum", 256'(bus.out_psum), 256'(mon_e.psum));
                chk("in_ready_in_hold", 256'(bus.in_ready), 256'(0));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end
    initial begin
        int t1[7] = '{4, 6, 3, 2, 2, 3, 5};
        bus.in_valid  = 1'b0;
        bus.in_len    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_err", 256'(bus.err), 256'(0));
        chk("rst_out_inum", 256'(bus.out_inum), 256'(0));
        // 1: seven elements closed by last
        foreach (t1[i]) add(t1[i]);
        push();
        foreach (t1[i]) send(t1[i], i == 6);
        drain();
        // 2: fourth element leaves 31 used, the fifth spills into the next batch
        add(8); add(8); add(8); add(7); push();
        add(3); add(2); push();
        send(8, 0); send(8, 0); send(8, 0); send(7, 0); send(3, 0); send(2, 1);
        drain();
        // 3: exact fill closes the batch, one cycle latency
        repeat (4) add(8);
        push();
        send(8, 0); send(8, 0); send(8, 0);
        @(negedge clk);
        chk("fill_not_closed_early", 256'(bus.out_valid), 256'(0));
        send(8, 0);
        @(negedge clk);
        chk("fill_latency", 256'(bus.out_valid), 256'(1));
        drain();
        // 4: count cap
        repeat (32) add(1);
        push();
        repeat (32) send(1, 0);
        drain();
        // 5: back-pressure holds the descriptor stable
        bus.out_ready = 1'b0;
        add(5); add(6); push();
        send(5, 0); send(6, 1);
        @(negedge clk);
        chk("hold_valid", 256'(bus.out_valid), 256'(1));
        s_inum = bus.out_inum;
        s_ilen = bus.out_ilen;
        s_ipos = bus.out_ipos;
        s_psum = bus.out_psum;
        repeat (5) begin
            @(negedge clk);
            chk("hold_stable_inum", 256'(bus.out_inum), 256'(s_inum));
            chk("hold_stable_ilen", 256'(bus.out_ilen), 256'(s_ilen));
            chk("hold_stable_ipos", 256'(bus.out_ipos), 256'(s_ipos));
            chk("hold_stable_psum", 256'(bus.out_psum), 256'(s_psum));
            chk("hold_in_ready", 256'(bus.in_ready), 256'(0));
            chk("hold_still_valid", 256'(bus.out_valid), 256'(1));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("single_transfer", 256'(bus.out_valid), 256'(0));
        drain();
        // 7: spilled element carrying last becomes its own batch
        add(10); add(10); add(10); push();
        add(5); push();
        send(10, 0); send(10, 0); send(10, 0); send(5, 1);
        drain();
        chk("carry_last_back_to_fill", 256'(bus.in_ready), 256'(1));
        // 6: illegal length is dropped and err is sticky
        send(0, 0);
        @(negedge clk);
        chk("err_set", 256'(bus.err), 256'(1));
        add(5); push();
        send(5, 1);
        drain();
        chk("err_sticky", 256'(bus.err), 256'(1));
        // 6: reset mid-batch discards the partial batch and clears err
        send(3, 0); send(4, 0); send(5, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("post_rst_err", 256'(bus.err), 256'(0));
        chk("post_rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("post_rst_inum", 256'(bus.out_inum), 256'(0));
        add(2); push();
        send(2, 1);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
